// File: rtl/valid_sync_bank.sv
// Multi-channel async valid/flag synchroniser with glitch filter, level or toggle-to-pulse mode and edge events.
// Optional sticky event flags are built when VALID_SYNC_BANK_STICKY_EN is defined.
module valid_sync_bank #(
  parameter int unsigned          CHANNELS   = 4,
  parameter int unsigned          DEPTH      = 3,
  parameter logic [CHANNELS-1:0]  INIT       = '0,
  parameter int unsigned          FILTER     = 0,
  parameter logic [CHANNELS-1:0]  PULSE_MASK = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] io_in,
`ifdef VALID_SYNC_BANK_STICKY_EN
  input  logic [CHANNELS-1:0] io_clear,
  output logic [CHANNELS-1:0] io_sticky,
`endif
  output logic [CHANNELS-1:0] io_out,
  output logic [CHANNELS-1:0] io_rise,
  output logic [CHANNELS-1:0] io_fall
);

  localparam int unsigned CW = (FILTER == 0) ? 1 : $clog2(FILTER + 1);

  logic [DEPTH-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]            sq;
  logic [CHANNELS-1:0]            filt_q;
  logic [CHANNELS-1:0]            filt_d;
  logic [CHANNELS-1:0]            hist_q;
  logic [CHANNELS-1:0][CW-1:0]    cnt_q;
  logic [CHANNELS-1:0][CW-1:0]    cnt_d;

  assign sq = sync_q[DEPTH-1];

  // Synchroniser chain, filter state and edge history
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= {DEPTH{INIT}};
      filt_q <= INIT;
      hist_q <= INIT;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], io_in};
      filt_q <= filt_d;
      hist_q <= filt_q;
      cnt_q  <= cnt_d;
    end
  end

  // Filter: sq must disagree with filt for FILTER+1 consecutive samples to be accepted
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sq[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CW'(FILTER)) begin
        filt_d[i] = sq[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  assign io_rise = filt_q & ~hist_q;
  assign io_fall = ~filt_q & hist_q;
  assign io_out  = (PULSE_MASK & (filt_q ^ hist_q)) | (~PULSE_MASK & filt_q);

`ifdef VALID_SYNC_BANK_STICKY_EN
  logic [CHANNELS-1:0] sticky_set;
  logic [CHANNELS-1:0] sticky_q;

  assign sticky_set = (PULSE_MASK & io_out) | (~PULSE_MASK & io_rise);

  // A new event in the same cycle as a clear keeps the flag set
  always_ff @(posedge clock) begin
    if (reset) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= (sticky_q & ~io_clear) | sticky_set;
    end
  end

  assign io_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_valid_sync_bank.sv
// Scoreboard bench for valid_sync_bank: u0 unfiltered with channel 2 in toggle mode, u1 with FILTER=2.
module tb_valid_sync_bank;

  localparam logic [3:0] PM0 = 4'b0100;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_PULSE = 2;
  localparam int K_UP = 3;
  localparam int K_DN = 4;
  localparam int K_SUP = 5;
  localparam int K_SDN = 6;

  typedef struct {
    int cyc;
    int inst;
    int ch;
    int kind;
  } ev_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] in0 = 4'b0000;
  logic [3:0] in1 = 4'b0000;
  logic [3:0] out0, rise0, fall0, out1, rise1, fall1;
  logic [3:0] prev0 = 4'b0000;
  logic [3:0] prev1 = 4'b0000;
`ifdef VALID_SYNC_BANK_STICKY_EN
  logic [3:0] clear = 4'b1111;
  logic [3:0] sticky0, sticky1;
  logic [3:0] sprev0 = 4'b0000;
  logic [3:0] sprev1 = 4'b0000;
`endif

  int   cyc = 0;
  bit   rst_seen = 1'b0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];

  valid_sync_bank #(
    .CHANNELS(4), .DEPTH(3), .INIT(4'b0000), .FILTER(0), .PULSE_MASK(PM0)
  ) u0 (
    .clock(clock), .reset(reset), .io_in(in0),
`ifdef VALID_SYNC_BANK_STICKY_EN
    .io_clear(clear), .io_sticky(sticky0),
`endif
    .io_out(out0), .io_rise(rise0), .io_fall(fall0)
  );

  valid_sync_bank #(
    .CHANNELS(4), .DEPTH(3), .INIT(4'b0000), .FILTER(2), .PULSE_MASK(4'b0000)
  ) u1 (
    .clock(clock), .reset(reset), .io_in(in1),
`ifdef VALID_SYNC_BANK_STICKY_EN
    .io_clear(clear), .io_sticky(sticky1),
`endif
    .io_out(out1), .io_rise(rise1), .io_fall(fall1)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_seen <= reset;
  end

  function automatic void push(input int c, input int inst, input int ch, input int kind);
    ev_t e;
    e.cyc = c; e.inst = inst; e.ch = ch; e.kind = kind;
    exp_q.push_back(e);
  endfunction

  // Expected events for one filtered-state change visible in cycle c
  function automatic void edge_ev(input int inst, input int ch, input int c, input bit up);
    bit tog;
    tog = (inst == 0) && PM0[ch];
    push(c, inst, ch, up ? K_RISE : K_FALL);
    if (tog) push(c, inst, ch, K_PULSE);
    else     push(c, inst, ch, up ? K_UP : K_DN);
`ifdef VALID_SYNC_BANK_STICKY_EN
    if (up || tog) begin
      push(c + 1, inst, ch, K_SUP);
      push(c + 2, inst, ch, K_SDN);
    end
`endif
  endfunction

  task automatic observe(input int inst, input int ch, input int kind);
    int idx;
    idx = -1;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (exp_q[i].cyc == cyc && exp_q[i].inst == inst && exp_q[i].ch == ch && exp_q[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    checks++;
    if (idx >= 0) exp_q.delete(idx);
    else begin
      errors++;
      $display("FAIL unexpected_event inst=%0d ch=%0d kind=%0d cycle=%0d: observed=1 required=0", inst, ch, kind, cyc);
    end
  endtask

  task automatic scan(input int inst, input logic [3:0] pm, input logic [3:0] o,
                      input logic [3:0] r, input logic [3:0] f, input logic [3:0] p);
    for (int ch = 0; ch < 4; ch++) begin
      if (r[ch]) observe(inst, ch, K_RISE);
      if (f[ch]) observe(inst, ch, K_FALL);
      if (pm[ch]) begin
        if (o[ch]) observe(inst, ch, K_PULSE);
      end else if (o[ch] != p[ch]) begin
        observe(inst, ch, o[ch] ? K_UP : K_DN);
      end
    end
  endtask

  task automatic reset_chk(input int inst, input logic [11:0] v);
    checks++;
    if (v !== 12'h000) begin
      errors++;
      $display("FAIL reset_state inst=%0d out/rise/fall=%b required 000000000000", inst, v);
    end
  endtask

  // Monitor: every observed event must match a queued expectation in the same cycle
  always @(negedge clock) begin
    if (rst_seen) begin
      reset_chk(0, {out0, rise0, fall0});
      reset_chk(1, {out1, rise1, fall1});
    end
    scan(0, PM0, out0, rise0, fall0, prev0);
    scan(1, 4'b0000, out1, rise1, fall1, prev1);
    prev0 = out0;
    prev1 = out1;
`ifdef VALID_SYNC_BANK_STICKY_EN
    for (int ch = 0; ch < 4; ch++) begin
      if (sticky0[ch] != sprev0[ch]) observe(0, ch, sticky0[ch] ? K_SUP : K_SDN);
      if (sticky1[ch] != sprev1[ch]) observe(1, ch, sticky1[ch] ? K_SUP : K_SDN);
    end
    sprev0 = sticky0;
    sprev1 = sticky1;
`endif
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_event inst=%0d ch=%0d kind=%0d cycle=%0d: observed=0 required=1",
                 exp_q[i].inst, exp_q[i].ch, exp_q[i].kind, exp_q[i].cyc);
        exp_q.delete(i);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask

  initial begin
    int e;
    tick(4);
    reset = 1'b0;
    tick(5);

    // Level channel 0: rise then fall, DEPTH-cycle latency
    in0[0] = 1'b1; e = cyc + 1; edge_ev(0, 0, e + 3, 1'b1);
    tick(6);
    in0[0] = 1'b0; e = cyc + 1; edge_ev(0, 0, e + 3, 1'b0);
    tick(6);

    // Toggle channel 2: two toggles ten cycles apart
    in0[2] = 1'b1; e = cyc + 1; edge_ev(0, 2, e + 3, 1'b1);
    tick(10);
    in0[2] = 1'b0; e = cyc + 1; edge_ev(0, 2, e + 3, 1'b0);
    tick(6);

    // Simultaneous events on channels 1 and 3
    in0[1] = 1'b1; in0[3] = 1'b1; e = cyc + 1;
    edge_ev(0, 1, e + 3, 1'b1); edge_ev(0, 3, e + 3, 1'b1);
    tick(6);
    in0[1] = 1'b0; in0[3] = 1'b0; e = cyc + 1;
    edge_ev(0, 1, e + 3, 1'b0); edge_ev(0, 3, e + 3, 1'b0);
    tick(6);

    // FILTER=2: a 2-cycle glitch is rejected
    in1[1] = 1'b1; tick(2); in1[1] = 1'b0; tick(8);
    // Two 2-cycle glitches with a 1-cycle gap: counter restarts, still rejected
    in1[1] = 1'b1; tick(2); in1[1] = 1'b0; tick(1); in1[1] = 1'b1; tick(2); in1[1] = 1'b0; tick(10);
    // 3-cycle pulse is just long enough
    in1[1] = 1'b1; e = cyc + 1; edge_ev(1, 1, e + 5, 1'b1);
    tick(3);
    in1[1] = 1'b0; e = cyc + 1; edge_ev(1, 1, e + 5, 1'b0);
    tick(10);
    // 4-cycle hold
    in1[1] = 1'b1; e = cyc + 1; edge_ev(1, 1, e + 5, 1'b1);
    tick(4);
    in1[1] = 1'b0; e = cyc + 1; edge_ev(1, 1, e + 5, 1'b0);
    tick(10);

    // Inputs high during reset: nothing until DEPTH+1 edges after release
    reset = 1'b1; in0 = 4'b1111;
    tick(4);
    reset = 1'b0; e = cyc + 1;
    for (int ch = 0; ch < 4; ch++) edge_ev(0, ch, e + 3, 1'b1);
    tick(6);
    in0 = 4'b0000; e = cyc + 1;
    for (int ch = 0; ch < 4; ch++) edge_ev(0, ch, e + 3, 1'b0);
    tick(6);

    // Reset mid-propagation on channel 3 discards the in-flight change
    in0[3] = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0; e = cyc + 1; edge_ev(0, 3, e + 3, 1'b1);
    tick(6);
    in0[3] = 1'b0; e = cyc + 1; edge_ev(0, 3, e + 3, 1'b0);
    tick(6);

    // Reset while level channel 0 is high: output drops to INIT with no fall pulse
    in0[0] = 1'b1; e = cyc + 1; edge_ev(0, 0, e + 3, 1'b1);
    tick(6);
    reset = 1'b1; push(cyc + 1, 0, 0, K_DN);
    tick(3);
    reset = 1'b0; e = cyc + 1; edge_ev(0, 0, e + 3, 1'b1);
    tick(6);
    in0[0] = 1'b0; e = cyc + 1; edge_ev(0, 0, e + 3, 1'b0);
    tick(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
